// File: rtl/wb_fsmc_master.sv
// wb_fsmc_master
//   Wishbone slave that turns each 32-bit access into one or two 16-bit
//   asynchronous-SRAM style FSMC bus cycles. Each cycle is built from three
//   timed phases: address setup, data strobe and hold. All phase timing
//   comes from 8-bit down-counters in the single clock domain.
//
//   Optional build macro: FSMC_NWAIT_EN adds the fsmc_nwait input. While it
//   is low at the end of the data phase, the strobe phase is stretched.
//
// Ports
//   clk, rst            system clock, synchronous active-low reset
//   wbs_*               Wishbone classic slave (24-bit byte address, 32-bit data)
//   fsmc_adr            halfword address {adr[16:2], half}
//   fsmc_dat_o/_i       pad write / read data
//   fsmc_data_out_en    pad output enable (writes only, during CE low)
//   fsmc_ce_n/we_n/oe_n chip enable and strobes, active low
//   fsmc_ub_n/lb_n      byte lanes of the current half, active low
//   fsmc_nwait          target wait request, active low (FSMC_NWAIT_EN only)
//   busy                state is not IDLE
//
// State  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for a Wishbone request
// SETUP  | CE, address and lanes driven, strobes inactive
// DATA   | nWE (write) or nOE (read) low; reads sample at the end
// HOLD   | strobes released, CE/address/lanes/data still driven
// GAP    | one cycle with CE high between the two halves
// ACK    | single-cycle Wishbone acknowledge

module wb_fsmc_master #(
  parameter int ADDR_SETUP = 2,
  parameter int DATA_PHASE = 4,
  parameter int BUS_HOLD   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic [31:0] wbs_dat_o,
  input  logic [3:0]  wbs_sel_i,
  input  logic        wbs_we_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  output logic        wbs_ack_o,
  output logic [15:0] fsmc_adr,
  output logic [15:0] fsmc_dat_o,
  input  logic [15:0] fsmc_dat_i,
  output logic        fsmc_data_out_en,
  output logic        fsmc_ce_n,
  output logic        fsmc_we_n,
  output logic        fsmc_oe_n,
  output logic        fsmc_ub_n,
  output logic        fsmc_lb_n,
`ifdef FSMC_NWAIT_EN
  input  logic        fsmc_nwait,
`endif
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_DATA  = 3'd2,
    S_HOLD  = 3'd3,
    S_GAP   = 3'd4,
    S_ACK   = 3'd5
  } state_t;

  // Counter reload values; a parameter of 0 behaves like 1.
  localparam logic [7:0] SETUP_LD = (ADDR_SETUP > 1) ? 8'(ADDR_SETUP - 1) : 8'd0;
  localparam logic [7:0] DATA_LD  = (DATA_PHASE > 1) ? 8'(DATA_PHASE - 1) : 8'd0;
  localparam logic [7:0] HOLD_LD  = (BUS_HOLD   > 1) ? 8'(BUS_HOLD   - 1) : 8'd0;

  state_t      state, state_nxt;
  logic        half, half_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic [14:0] adr_q, adr_nxt;
  logic [31:0] dat_q, dat_nxt;
  logic [3:0]  sel_q, sel_nxt;
  logic        we_q, we_nxt;
  logic [31:0] rd_q, rd_nxt;

  logic [31:0] wbs_dat_o_nxt;
  logic        wbs_ack_o_nxt;
  logic [15:0] fsmc_adr_nxt;
  logic [15:0] fsmc_dat_o_nxt;
  logic        fsmc_data_out_en_nxt;
  logic        fsmc_ce_n_nxt;
  logic        fsmc_we_n_nxt;
  logic        fsmc_oe_n_nxt;
  logic        fsmc_ub_n_nxt;
  logic        fsmc_lb_n_nxt;
  logic        busy_nxt;

  logic        bus_nxt;
  logic [1:0]  lane_nxt;
  logic [31:0] byte_mask;
  logic        wait_ok;

  // Only adr[16:2] address the target; the rest is deliberately dropped.
  logic unused_adr_bits;
  assign unused_adr_bits = ^{wbs_adr_i[23:17], wbs_adr_i[1:0]};

`ifdef FSMC_NWAIT_EN
  assign wait_ok = fsmc_nwait;
`else
  assign wait_ok = 1'b1;
`endif

  always_comb begin
    state_nxt = state;
    half_nxt  = half;
    cnt_nxt   = cnt;
    adr_nxt   = adr_q;
    dat_nxt   = dat_q;
    sel_nxt   = sel_q;
    we_nxt    = we_q;
    rd_nxt    = rd_q;

    case (state)
      S_IDLE: begin
        if (wbs_cyc_i && wbs_stb_i && !wbs_ack_o) begin
          adr_nxt = wbs_adr_i[16:2];
          dat_nxt = wbs_dat_i;
          sel_nxt = wbs_sel_i;
          we_nxt  = wbs_we_i;
          rd_nxt  = 32'd0;
          if (wbs_sel_i == 4'd0) begin
            state_nxt = S_ACK;
          end else begin
            state_nxt = S_SETUP;
            half_nxt  = (wbs_sel_i[1:0] == 2'b00);
            cnt_nxt   = SETUP_LD;
          end
        end
      end

      S_SETUP: begin
        if (cnt == 8'd0) begin
          state_nxt = S_DATA;
          cnt_nxt   = DATA_LD;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end

      S_DATA: begin
        if (cnt != 8'd0) begin
          cnt_nxt = cnt - 8'd1;
        end else if (wait_ok) begin
          // Read data is captured on the final strobe cycle only.
          if (!we_q) begin
            if (half) rd_nxt[31:16] = fsmc_dat_i;
            else      rd_nxt[15:0]  = fsmc_dat_i;
          end
          state_nxt = S_HOLD;
          cnt_nxt   = HOLD_LD;
        end
      end

      S_HOLD: begin
        if (cnt != 8'd0) begin
          cnt_nxt = cnt - 8'd1;
        end else if (!half && (sel_q[3:2] != 2'b00) && wbs_cyc_i) begin
          state_nxt = S_GAP;
        end else if (wbs_cyc_i) begin
          state_nxt = S_ACK;
        end else begin
          state_nxt = S_IDLE;
        end
      end

      S_GAP: begin
        state_nxt = S_SETUP;
        half_nxt  = 1'b1;
        cnt_nxt   = SETUP_LD;
      end

      S_ACK: begin
        state_nxt = S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Outputs are computed from the next state so that, once registered, they
  // line up with the state they belong to.
  always_comb begin
    bus_nxt  = (state_nxt == S_SETUP) || (state_nxt == S_DATA) || (state_nxt == S_HOLD);
    lane_nxt = half_nxt ? sel_nxt[3:2] : sel_nxt[1:0];

    fsmc_ce_n_nxt        = !bus_nxt;
    fsmc_ub_n_nxt        = bus_nxt ? !lane_nxt[1] : 1'b1;
    fsmc_lb_n_nxt        = bus_nxt ? !lane_nxt[0] : 1'b1;
    fsmc_data_out_en_nxt = bus_nxt && we_nxt;
    fsmc_we_n_nxt        = !((state_nxt == S_DATA) && we_nxt);
    fsmc_oe_n_nxt        = !((state_nxt == S_DATA) && !we_nxt);

    // Address and write data only change on entry to SETUP and are held
    // everywhere else, including through GAP.
    fsmc_adr_nxt   = fsmc_adr;
    fsmc_dat_o_nxt = fsmc_dat_o;
    if (state_nxt == S_SETUP) begin
      fsmc_adr_nxt   = {adr_nxt, half_nxt};
      fsmc_dat_o_nxt = half_nxt ? dat_nxt[31:16] : dat_nxt[15:0];
    end

    byte_mask = {{8{sel_nxt[3]}}, {8{sel_nxt[2]}}, {8{sel_nxt[1]}}, {8{sel_nxt[0]}}};

    wbs_ack_o_nxt = (state_nxt == S_ACK);
    wbs_dat_o_nxt = ((state_nxt == S_ACK) && !we_nxt) ? (rd_nxt & byte_mask) : 32'd0;
    busy_nxt      = (state_nxt != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state            <= S_IDLE;
      half             <= 1'b0;
      cnt              <= 8'd0;
      adr_q            <= 15'd0;
      dat_q            <= 32'd0;
      sel_q            <= 4'd0;
      we_q             <= 1'b0;
      rd_q             <= 32'd0;
      wbs_dat_o        <= 32'd0;
      wbs_ack_o        <= 1'b0;
      fsmc_adr         <= 16'd0;
      fsmc_dat_o       <= 16'd0;
      fsmc_data_out_en <= 1'b0;
      fsmc_ce_n        <= 1'b1;
      fsmc_we_n        <= 1'b1;
      fsmc_oe_n        <= 1'b1;
      fsmc_ub_n        <= 1'b1;
      fsmc_lb_n        <= 1'b1;
      busy             <= 1'b0;
    end else begin
      state            <= state_nxt;
      half             <= half_nxt;
      cnt              <= cnt_nxt;
      adr_q            <= adr_nxt;
      dat_q            <= dat_nxt;
      sel_q            <= sel_nxt;
      we_q             <= we_nxt;
      rd_q             <= rd_nxt;
      wbs_dat_o        <= wbs_dat_o_nxt;
      wbs_ack_o        <= wbs_ack_o_nxt;
      fsmc_adr         <= fsmc_adr_nxt;
      fsmc_dat_o       <= fsmc_dat_o_nxt;
      fsmc_data_out_en <= fsmc_data_out_en_nxt;
      fsmc_ce_n        <= fsmc_ce_n_nxt;
      fsmc_we_n        <= fsmc_we_n_nxt;
      fsmc_oe_n        <= fsmc_oe_n_nxt;
      fsmc_ub_n        <= fsmc_ub_n_nxt;
      fsmc_lb_n        <= fsmc_lb_n_nxt;
      busy             <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_wb_fsmc_master.sv
// Directed bench for wb_fsmc_master with default timing parameters.
// Each request is traced for 40 cycles after its accept edge; per-cycle
// strobe activity is collected into bit masks (bit k = cycle k) and compared
// against hand-computed values.

module tb_wb_fsmc_master;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [23:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_dat_o;
  logic [3:0]  wbs_sel_i;
  logic        wbs_we_i;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_ack_o;
  logic [15:0] fsmc_adr;
  logic [15:0] fsmc_dat_o;
  logic [15:0] fsmc_dat_i;
  logic        fsmc_data_out_en;
  logic        fsmc_ce_n;
  logic        fsmc_we_n;
  logic        fsmc_oe_n;
  logic        fsmc_ub_n;
  logic        fsmc_lb_n;
  logic        busy;
`ifdef FSMC_NWAIT_EN
  logic        fsmc_nwait;
`endif

  wb_fsmc_master dut (
    .clk              (clk),
    .rst              (rst),
    .wbs_adr_i        (wbs_adr_i),
    .wbs_dat_i        (wbs_dat_i),
    .wbs_dat_o        (wbs_dat_o),
    .wbs_sel_i        (wbs_sel_i),
    .wbs_we_i         (wbs_we_i),
    .wbs_cyc_i        (wbs_cyc_i),
    .wbs_stb_i        (wbs_stb_i),
    .wbs_ack_o        (wbs_ack_o),
    .fsmc_adr         (fsmc_adr),
    .fsmc_dat_o       (fsmc_dat_o),
    .fsmc_dat_i       (fsmc_dat_i),
    .fsmc_data_out_en (fsmc_data_out_en),
    .fsmc_ce_n        (fsmc_ce_n),
    .fsmc_we_n        (fsmc_we_n),
    .fsmc_oe_n        (fsmc_oe_n),
    .fsmc_ub_n        (fsmc_ub_n),
    .fsmc_lb_n        (fsmc_lb_n),
`ifdef FSMC_NWAIT_EN
    .fsmc_nwait       (fsmc_nwait),
`endif
    .busy             (busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Per-cycle trace of one request.
  logic [15:0] tr_adr  [0:40];
  logic [15:0] tr_dato [0:40];
  logic        tr_ub   [0:40];
  logic        tr_lb   [0:40];
  logic        tr_busy [0:40];
  logic [63:0] m_ce, m_we, m_oe, m_en;
  int          ack_cyc, ack_cnt;
  logic [31:0] ack_dat;

  // Target model knobs: pad data is valid only in cycle samp_k; nwait is
  // held low in cycles nw_lo..nw_hi.
  int          nw_lo, nw_hi, samp_k;
  logic [15:0] pad_good;

  task automatic run_req(input logic [23:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic w, input int drop_at);
    @(negedge clk);
    wbs_adr_i  = a;
    wbs_dat_i  = d;
    wbs_sel_i  = s;
    wbs_we_i   = w;
    wbs_cyc_i  = 1'b1;
    wbs_stb_i  = 1'b1;
    fsmc_dat_i = 16'hDEAD;
`ifdef FSMC_NWAIT_EN
    fsmc_nwait = 1'b1;
`endif
    m_ce = '0; m_we = '0; m_oe = '0; m_en = '0;
    ack_cyc = -1; ack_cnt = 0; ack_dat = '0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      tr_adr[k]  = fsmc_adr;
      tr_dato[k] = fsmc_dat_o;
      tr_ub[k]   = fsmc_ub_n;
      tr_lb[k]   = fsmc_lb_n;
      tr_busy[k] = busy;
      m_ce[k]    = ~fsmc_ce_n;
      m_we[k]    = ~fsmc_we_n;
      m_oe[k]    = ~fsmc_oe_n;
      m_en[k]    = fsmc_data_out_en;
      if (wbs_ack_o) begin
        ack_cnt++;
        if (ack_cyc < 0) begin
          ack_cyc = k;
          ack_dat = wbs_dat_o;
        end
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
      end
      if (k == drop_at) begin
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
      end
`ifdef FSMC_NWAIT_EN
      fsmc_nwait = !(k >= nw_lo && k <= nw_hi);
`endif
      fsmc_dat_i = (k == samp_k) ? pad_good : 16'hDEAD;
    end
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
  endtask

  initial begin
    rst        = 1'b0;
    wbs_adr_i  = '0;
    wbs_dat_i  = '0;
    wbs_sel_i  = '0;
    wbs_we_i   = 1'b0;
    wbs_cyc_i  = 1'b0;
    wbs_stb_i  = 1'b0;
    fsmc_dat_i = 16'hDEAD;
`ifdef FSMC_NWAIT_EN
    fsmc_nwait = 1'b1;
`endif
    nw_lo = 100; nw_hi = 0; samp_k = -1; pad_good = 16'h0000;

    repeat (3) @(negedge clk);
    chk("rst_ce_we_oe_ub_lb", {59'd0, fsmc_ce_n, fsmc_we_n, fsmc_oe_n, fsmc_ub_n, fsmc_lb_n}, 64'h1F);
    chk("rst_misc", {29'd0, fsmc_data_out_en, wbs_ack_o, busy, fsmc_adr, fsmc_dat_o}, 64'd0);
    chk("rst_wbs_dat", {32'd0, wbs_dat_o}, 64'd0);
    rst = 1'b1;
    @(negedge clk);

    // Two-half write
    run_req(24'h000010, 32'hA5A5_1234, 4'hF, 1'b1, -1);
    chk("wr2_ce_mask", m_ce, 64'hFEFE);
    chk("wr2_we_mask", m_we, 64'h7878);
    chk("wr2_oe_mask", m_oe, 64'h0);
    chk("wr2_en_mask", m_en, 64'hFEFE);
    chk("wr2_adr_lo",  {48'd0, tr_adr[3]},  64'h0008);
    chk("wr2_dat_lo",  {48'd0, tr_dato[3]}, 64'h1234);
    chk("wr2_adr_hi",  {48'd0, tr_adr[11]}, 64'h0009);
    chk("wr2_dat_hi",  {48'd0, tr_dato[11]}, 64'hA5A5);
    chk("wr2_ack_cyc", 64'(ack_cyc), 64'd16);
    chk("wr2_ack_cnt", 64'(ack_cnt), 64'd1);
    chk("wr2_ack_dat", {32'd0, ack_dat}, 64'd0);

    // Low-half read
    samp_k = 6; pad_good = 16'hBEEF;
    run_req(24'h000004, 32'h0, 4'h3, 1'b0, -1);
    chk("rd_ce_mask", m_ce, 64'hFE);
    chk("rd_oe_mask", m_oe, 64'h78);
    chk("rd_we_mask", m_we, 64'h0);
    chk("rd_en_mask", m_en, 64'h0);
    chk("rd_adr",     {48'd0, tr_adr[4]}, 64'h0002);
    chk("rd_lanes",   {62'd0, tr_ub[4], tr_lb[4]}, 64'h0);
    chk("rd_ack_cyc", 64'(ack_cyc), 64'd8);
    chk("rd_ack_dat", {32'd0, ack_dat}, 64'h0000_BEEF);

    // High-half read, upper byte unselected must read as zero
    samp_k = 6; pad_good = 16'h12AB;
    run_req(24'h000008, 32'h0, 4'h4, 1'b0, -1);
    chk("rdh_adr",     {48'd0, tr_adr[3]}, 64'h0005);
    chk("rdh_lanes",   {62'd0, tr_ub[3], tr_lb[3]}, 64'h2);
    chk("rdh_ack_dat", {32'd0, ack_dat}, 64'h00AB_0000);
    samp_k = -1;

    // High byte write only
    run_req(24'h000020, 32'h1122_3344, 4'h8, 1'b1, -1);
    chk("wrh_ce_mask", m_ce, 64'hFE);
    chk("wrh_we_mask", m_we, 64'h78);
    chk("wrh_adr",     {48'd0, tr_adr[3]}, 64'h0011);
    chk("wrh_dat",     {48'd0, tr_dato[3]}, 64'h1122);
    chk("wrh_lanes",   {62'd0, tr_ub[3], tr_lb[3]}, 64'h1);
    chk("wrh_ack_cyc", 64'(ack_cyc), 64'd8);

    // Nothing selected
    run_req(24'h000030, 32'hFFFF_FFFF, 4'h0, 1'b1, -1);
    chk("sel0_ack_cyc", 64'(ack_cyc), 64'd1);
    chk("sel0_ack_cnt", 64'(ack_cnt), 64'd1);
    chk("sel0_ce_mask", m_ce, 64'h0);

    // cyc dropped during the first data phase of a two-half write
    run_req(24'h000040, 32'hCAFE_F00D, 4'hF, 1'b1, 4);
    chk("abort_ce_mask", m_ce, 64'hFE);
    chk("abort_we_mask", m_we, 64'h78);
    chk("abort_ack_cnt", 64'(ack_cnt), 64'd0);
    chk("abort_busy8",   {63'd0, tr_busy[8]}, 64'd0);

`ifdef FSMC_NWAIT_EN
    // Target stretches the read strobe by three cycles
    nw_lo = 6; nw_hi = 8; samp_k = 9; pad_good = 16'hBEEF;
    run_req(24'h000004, 32'h0, 4'h3, 1'b0, -1);
    chk("nw_oe_mask", m_oe, 64'h3F8);
    chk("nw_ce_mask", m_ce, 64'h7FE);
    chk("nw_ack_cyc", 64'(ack_cyc), 64'd11);
    chk("nw_ack_dat", {32'd0, ack_dat}, 64'h0000_BEEF);
    nw_lo = 100; nw_hi = 0; samp_k = -1;
`endif

    // Reset asserted while the first half is in DATA
    @(negedge clk);
    wbs_adr_i = 24'h000010;
    wbs_dat_i = 32'h5555_AAAA;
    wbs_sel_i = 4'hF;
    wbs_we_i  = 1'b1;
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    repeat (4) @(negedge clk);
    chk("mid_we_low", {63'd0, fsmc_we_n}, 64'd0);
    rst       = 1'b0;
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    @(negedge clk);
    chk("mid_rst_strobes", {59'd0, fsmc_ce_n, fsmc_we_n, fsmc_oe_n, fsmc_ub_n, fsmc_lb_n}, 64'h1F);
    chk("mid_rst_misc", {29'd0, fsmc_data_out_en, wbs_ack_o, busy, fsmc_adr, fsmc_dat_o}, 64'd0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", {62'd0, busy, wbs_ack_o}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
